// File: rtl/serial_comp_rx.sv
// ---------------------------------------------------------------------------
// serial_comp_rx
//   Bit-serial magnitude/equality comparator. Two operands arrive MSB first,
//   one bit pair per accepted beat. After WIDTH beats the block reports
//   eq/gt/lt (unsigned) and pulses done for one cycle.
//
// Ports
//   clk_i        rising-edge clock
//   reset_i      asynchronous, active-high reset
//   start_i      begin a new comparison (sampled only in IDLE or DONE)
//   bit_valid_i  a_bit_i/b_bit_i carry a valid beat this cycle
//   a_bit_i      serial operand A, MSB first
//   b_bit_i      serial operand B, MSB first
//   busy_o       high while a comparison is in progress
//   done_o       one-cycle pulse; results valid from this cycle on
//   eq_o         A == B
//   gt_o         A >  B
//   lt_o         A <  B
// ---------------------------------------------------------------------------
module serial_comp_rx #(
    parameter int unsigned WIDTH = 5
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic start_i,
    input  logic bit_valid_i,
    input  logic a_bit_i,
    input  logic b_bit_i,
    output logic busy_o,
    output logic done_o,
    output logic eq_o,
    output logic gt_o,
    output logic lt_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCompare,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            decided_q, decided_d;
    logic            sign_q, sign_d;   // 1: A greater, 0: A less (valid once decided)
    logic            eq_q, eq_d;
    logic            gt_q, gt_d;
    logic            lt_q, lt_d;

    logic            accept_start;
    logic            decided_now;
    logic            sign_now;

    assign accept_start = start_i && ((state_q == StIdle) || (state_q == StDone));

    // First differing bit pair fixes the order; later beats cannot change it.
    assign decided_now = decided_q | (a_bit_i ^ b_bit_i);
    assign sign_now    = decided_q ? sign_q : a_bit_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        sign_d    = sign_q;
        eq_d      = eq_q;
        gt_d      = gt_q;
        lt_d      = lt_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StCompare;
                end
            end
            StCompare: begin
                if (bit_valid_i) begin
                    decided_d = decided_now;
                    sign_d    = sign_now;
                    if (cnt_q == LastBeat) begin
                        state_d = StDone;
                        cnt_d   = '0;
                        eq_d    = ~decided_now;
                        gt_d    = decided_now & sign_now;
                        lt_d    = decided_now & ~sign_now;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StDone: begin
                state_d = start_i ? StCompare : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A newly accepted start discards the previous result.
        if (accept_start) begin
            cnt_d     = '0;
            decided_d = 1'b0;
            sign_d    = 1'b0;
            eq_d      = 1'b0;
            gt_d      = 1'b0;
            lt_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            sign_q    <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            sign_q    <= sign_d;
            eq_q      <= eq_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
        end
    end

    assign busy_o = (state_q == StCompare);
    assign done_o = (state_q == StDone);
    assign eq_o   = eq_q;
    assign gt_o   = gt_q;
    assign lt_o   = lt_q;

endmodule

// File: tb/tb_serial_comp_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_comp_rx
//   Self-checking bench for serial_comp_rx. Directed cases followed by
//   randomized operands, stalls and start pulses; expected results come from
//   plain unsigned comparison of the whole operands.
// ---------------------------------------------------------------------------
module tb_serial_comp_rx;

    localparam int unsigned W = 5;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic bit_valid;
    logic a_bit;
    logic b_bit;
    logic busy;
    logic done;
    logic eq;
    logic gt;
    logic lt;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    logic exp_eq;
    logic exp_gt;
    logic exp_lt;

    serial_comp_rx #(
        .WIDTH(W)
    ) u_dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start),
        .bit_valid_i(bit_valid),
        .a_bit_i    (a_bit),
        .b_bit_i    (b_bit),
        .busy_o     (busy),
        .done_o     (done),
        .eq_o       (eq),
        .gt_o       (gt),
        .lt_o       (lt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one full comparison. Must be entered #1 after an edge with the DUT
    // in IDLE or DONE. Leaves the DUT in its DONE cycle.
    task automatic do_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input int stall_max,
                          input bit mid_start, input int gap_at, input int gap_len);
        int stalls;
        start     = 1'b1;
        bit_valid = 1'(($urandom));
        a_bit     = 1'(($urandom));
        b_bit     = 1'(($urandom));
        tick();
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("cleared_after_start", {29'd0, eq, gt, lt}, 32'd0);
        for (int i = W - 1; i >= 0; i--) begin
            stalls = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
            if (i == gap_at) stalls = gap_len;
            for (int k = 0; k < stalls; k++) begin
                bit_valid = 1'b0;
                a_bit     = 1'(($urandom));
                b_bit     = 1'(($urandom));
                start     = mid_start;
                tick();
                start = 1'b0;
                check("busy_in_stall", {31'd0, busy}, 32'd1);
                check("no_done_in_stall", {31'd0, done}, 32'd0);
            end
            bit_valid = 1'b1;
            a_bit     = a[i];
            b_bit     = b[i];
            start     = mid_start && (i == W - 2);
            tick();
            start     = 1'b0;
            bit_valid = 1'b0;
            if (i > 0) begin
                check("busy_mid", {31'd0, busy}, 32'd1);
                check("no_done_mid", {31'd0, done}, 32'd0);
                check("results_zero_mid", {29'd0, eq, gt, lt}, 32'd0);
            end
        end
        exp_eq = (a == b);
        exp_gt = (a > b);
        exp_lt = (a < b);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        check("eq", {31'd0, eq}, {31'd0, exp_eq});
        check("gt", {31'd0, gt}, {31'd0, exp_gt});
        check("lt", {31'd0, lt}, {31'd0, exp_lt});
    endtask

    // Idle cycles with junk on the serial inputs; results must hold.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            start     = 1'b0;
            bit_valid = 1'(($urandom));
            a_bit     = 1'(($urandom));
            b_bit     = 1'(($urandom));
            tick();
            check("idle_done_low", {31'd0, done}, 32'd0);
            check("idle_busy_low", {31'd0, busy}, 32'd0);
            check("idle_hold", {29'd0, eq, gt, lt}, {29'd0, exp_eq, exp_gt, exp_lt});
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           sel;

        reset     = 1'b1;
        start     = 1'b0;
        bit_valid = 1'b0;
        a_bit     = 1'b0;
        b_bit     = 1'b0;
        exp_eq    = 1'b0;
        exp_gt    = 1'b0;
        exp_lt    = 1'b0;
        #12;
        check("reset_outputs", {27'd0, busy, done, eq, gt, lt}, 32'd0);
        tick();
        reset = 1'b0;
        idle(2);

        // Equal operands, continuous beats
        do_cmp(5'b00100, 5'b00100, 0, 1'b0, -1, 0);
        idle(1);
        // A greater in a low bit, then equal
        do_cmp(5'b00010, 5'b00000, 0, 1'b0, -1, 0);
        idle(2);
        do_cmp(5'b00001, 5'b00001, 0, 1'b0, -1, 0);
        idle(1);
        // MSB decides even though every later bit opposes it
        do_cmp(5'b10000, 5'b01111, 0, 1'b0, -1, 0);
        idle(1);
        // Three-cycle gap between beats 2 and 3
        do_cmp(5'b01010, 5'b01100, 0, 1'b0, 2, 3);
        idle(1);
        // start during COMPARE ignored, then back-to-back start during DONE
        do_cmp(5'b11000, 5'b10111, 1, 1'b1, -1, 0);
        do_cmp(5'b00111, 5'b01000, 0, 1'b0, -1, 0);
        idle(1);

        // Reset after three beats aborts the comparison
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1;
            a_bit     = 1'b1;
            b_bit     = 1'(i);
            tick();
        end
        bit_valid = 1'b0;
        reset     = 1'b1;
        #2;
        check("abort_immediate", {27'd0, busy, done, eq, gt, lt}, 32'd0);
        tick();
        check("abort_held", {27'd0, busy, done, eq, gt, lt}, 32'd0);
        reset  = 1'b0;
        exp_eq = 1'b0;
        exp_gt = 1'b0;
        exp_lt = 1'b0;
        idle(1);
        do_cmp(5'b11111, 5'b11111, 0, 1'b0, -1, 0);
        idle(1);

        // Randomized operands, stalls, stray starts and back-to-back runs
        for (int n = 0; n < 60; n++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            sel = int'($urandom_range(3, 0));
            if (sel == 0) rb = ra;
            if (sel == 1) rb = ra ^ (W'(1) << $urandom_range(W - 1, 0));
            do_cmp(ra, rb, int'($urandom_range(2, 0)), 1'($urandom), -1, 0);
            if ($urandom_range(2, 0) != 0) idle(int'($urandom_range(2, 1)));
        end
        idle(1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
